// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with load, relative branch, increment,
// stall and call/return through a circular hardware return-address stack (RAS).
// Optional trap entry point is compiled in when PC_SEQ_TRAP_EN is defined; it adds
// the trap input and the epc output.
//
// Per-cycle request priority:
//   trap > stall > load_pc > ret > call > branch_en > incr_pc.
// Only the highest-priority asserted request acts; the others are dropped for that
// cycle. Every effect shows on pc one clock after the sampling edge.
module pc_sequencer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned TRAP_VEC  = 'h8
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef PC_SEQ_TRAP_EN
  input  logic             trap,
  output logic [WIDTH-1:0] epc,
`endif
  input  logic             stall,
  input  logic             load_pc,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             call,
  input  logic             ret,
  input  logic             incr_pc,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_VEC_W = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] TRAP_VEC_W  = WIDTH'(TRAP_VEC);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(RAS_DEPTH - 1);

  // The single action chosen for this cycle after priority resolution.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_TRAP,
    ACT_LOAD,
    ACT_RET,
    ACT_CALL,
    ACT_BRANCH,
    ACT_INCR
  } action_e;

  action_e          act;
  logic             trap_req;

  // RAS storage: wr_ptr is the next free slot, so the top of stack is wr_ptr-1.
  // Pushing when full simply overwrites the oldest entry, which is the circular
  // discard behaviour wanted on overflow.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_next, rd_ptr, inc_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [WIDTH-1:0] pc_next, ret_addr;
  logic             push_en, ovf_set, unf_set;

`ifdef PC_SEQ_TRAP_EN
  assign trap_req = trap;
`else
  assign trap_req = 1'b0;
`endif

  assign ret_addr = pc + STEP_W;
  assign rd_ptr   = (wr_ptr == '0) ? LAST_PTR : wr_ptr - PTR_W'(1);
  assign inc_ptr  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);

  // Priority resolution: pick exactly one action per cycle.
  always_comb begin
    act = ACT_HOLD;
    if (trap_req)       act = ACT_TRAP;
    else if (stall)     act = ACT_HOLD;
    else if (load_pc)   act = ACT_LOAD;
    else if (ret)       act = ACT_RET;
    else if (call)      act = ACT_CALL;
    else if (branch_en) act = ACT_BRANCH;
    else if (incr_pc)   act = ACT_INCR;
  end

  // Next pc, stack pointer/count and sticky-flag set requests for the chosen action.
  always_comb begin
    pc_next     = pc;
    wr_ptr_next = wr_ptr;
    count_next  = count;
    push_en     = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    case (act)
      ACT_TRAP:   pc_next = TRAP_VEC_W;
      ACT_LOAD:   pc_next = pc_in;
      ACT_RET: begin
        if (count != '0) begin
          pc_next     = ras_mem[rd_ptr];
          wr_ptr_next = rd_ptr;
          count_next  = count - CNT_W'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      ACT_CALL: begin
        push_en     = 1'b1;
        pc_next     = pc_in;
        wr_ptr_next = inc_ptr;
        if (count == FULL_CNT) ovf_set = 1'b1;
        else                   count_next = count + CNT_W'(1);
      end
      ACT_BRANCH: pc_next = pc + branch_off;
      ACT_INCR:   pc_next = pc + STEP_W;
      default:    pc_next = pc;
    endcase
  end

  // pc, stack bookkeeping and status flags; all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_VEC_W;
      wr_ptr    <= '0;
      count     <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else begin
      pc        <= pc_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      ras_empty <= (count_next == '0);
      ras_full  <= (count_next == FULL_CNT);
      ras_ovf   <= ras_ovf | ovf_set;
      ras_unf   <= ras_unf | unf_set;
    end
  end

  // Return-address storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) ras_mem[wr_ptr] <= ret_addr;
  end

`ifdef PC_SEQ_TRAP_EN
  // Exception pc captures the interrupted pc on trap entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              epc <= '0;
    else if (act == ACT_TRAP)  epc <= pc;
  end
`endif

endmodule
